// File: rtl/regfile_pkg.sv
// Shared register-file constants and width helpers, reused by the decode and hazard units.
package regfile_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_NREAD = 2;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/regfile_scoreboard_busy.sv
// Busy-bit scoreboard: per-register busy flags with claim > flush > writeback priority
// and an incrementally maintained count of busy registers.
module busy_scoreboard
    import regfile_pkg::*;
#(
    parameter int  DEPTH = DEF_DEPTH,
    localparam int AW    = addr_width(DEPTH),
    localparam int CW    = count_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             claim,
    input  logic [AW-1:0]    claim_addr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             flush,
    output logic [DEPTH-1:0] busy,
    output logic [CW-1:0]    busy_count
);

    logic [DEPTH-1:0] busy_next;
    logic [CW-1:0]    count_next;
    logic             inc;
    logic             dec;

    // NOTE: every always_comb output gets a default on entry so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        busy_next = busy;
        if (flush) begin
            busy_next = '0;
        end else if (wr_en) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (claim) begin
            busy_next[claim_addr] = 1'b1;
        end
    end

    // A claim on an idle register adds one; a writeback retires one unless the same
    // register is re-claimed this cycle by a new producer.
    always_comb begin
        inc = claim & ~busy[claim_addr];
        dec = wr_en & busy[wr_addr] & ~(claim && (claim_addr == wr_addr));
        if (flush) begin
            count_next = claim ? CW'(1) : '0;
        end else begin
            count_next = busy_count + CW'(inc) - CW'(dec);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with write-to-read bypass, optional zero register and
// an integrated busy-bit scoreboard for hazard detection.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int  WIDTH   = DEF_WIDTH,
    parameter int  DEPTH   = DEF_DEPTH,
    parameter int  NREAD   = DEF_NREAD,
    parameter int  BYPASS  = 1,
    parameter int  ZERO_R0 = 0,
    localparam int AW      = addr_width(DEPTH),
    localparam int CW      = count_width(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREAD*AW-1:0]    rd_addr,
    output logic [NREAD*WIDTH-1:0] rd_data,
    output logic [NREAD-1:0]       rd_busy,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   claim,
    input  logic [AW-1:0]          claim_addr,
    input  logic                   flush,
    output logic [CW-1:0]          busy_count,
    output logic                   all_idle
);

    localparam bit ZR = (ZERO_R0 != 0);
    localparam bit BP = (BYPASS != 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic             we_e;
    logic             cl_e;

    assign we_e = wr_en & ~(ZR && (wr_addr == '0));
    assign cl_e = claim & ~(ZR && (claim_addr == '0));

    // NOTE: the array is reset because the register file must read all-zero out of
    // reset; this forces flops rather than a RAM macro.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we_e) begin
            mem[wr_addr] <= wr_data;
        end
    end

    busy_scoreboard #(.DEPTH(DEPTH)) u_busy (
        .clock      (clock),
        .reset      (reset),
        .claim      (cl_e),
        .claim_addr (claim_addr),
        .wr_en      (we_e),
        .wr_addr    (wr_addr),
        .flush      (flush),
        .busy       (busy),
        .busy_count (busy_count)
    );

    assign all_idle = (busy_count == '0);

    for (genvar i = 0; i < NREAD; i++) begin : g_read
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
        logic             bsy;

        assign addr = rd_addr[i*AW +: AW];

        // A bypassed read sees the producer as retired unless it is re-claimed now.
        always_comb begin
            data = mem[addr];
            bsy  = busy[addr];
            if (BP && we_e && (wr_addr == addr)) begin
                data = wr_data;
                bsy  = (cl_e && (claim_addr == addr)) ? busy[addr] : 1'b0;
            end
            if (ZR && (addr == '0)) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign rd_data[i*WIDTH +: WIDTH] = data;
        assign rd_busy[i]                = bsy;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, zero-register/no-bypass sequences,
// and a randomized run against a behavioural model of two configurations.
module tb_regfile_scoreboard;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  rd_addr;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        claim;
    logic [2:0]  claim_addr;
    logic        flush;

    logic [31:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic [3:0]  cnt_a, cnt_b;
    logic        idle_a, idle_b;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    // Instance A: bypass on, r0 is an ordinary register.
    regfile_scoreboard #(.WIDTH(16), .DEPTH(8), .NREAD(2), .BYPASS(1), .ZERO_R0(0)) dut_a (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_busy(rd_busy_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim(claim), .claim_addr(claim_addr), .flush(flush),
        .busy_count(cnt_a), .all_idle(idle_a)
    );

    // Instance B: no bypass, hard-wired zero register.
    regfile_scoreboard #(.WIDTH(16), .DEPTH(8), .NREAD(2), .BYPASS(0), .ZERO_R0(1)) dut_b (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim(claim), .claim_addr(claim_addr), .flush(flush),
        .busy_count(cnt_b), .all_idle(idle_b)
    );

    typedef struct {
        logic        cl;
        logic [2:0]  ca;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        fl;
        logic [2:0]  ra;
        logic [15:0] e_data;
        logic        e_busy;
        logic [3:0]  e_cnt;
        logic        e_idle;
    } vec_t;

    vec_t tbl [17];

    logic [15:0] m_reg  [2][8];
    logic        m_busy [2][8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cl, input logic [2:0] ca, input logic we,
                         input logic [2:0] wa, input logic [15:0] wd, input logic fl,
                         input logic [5:0] ra);
        claim = cl; claim_addr = ca; wr_en = we; wr_addr = wa; wr_data = wd;
        flush = fl; rd_addr = ra;
    endtask

    function automatic vec_t mk(input logic cl, input logic [2:0] ca, input logic we,
                                input logic [2:0] wa, input logic [15:0] wd, input logic fl,
                                input logic [2:0] ra, input logic [15:0] ed, input logic eb,
                                input logic [3:0] ec, input logic ei);
        vec_t v;
        v.cl = cl; v.ca = ca; v.we = we; v.wa = wa; v.wd = wd; v.fl = fl; v.ra = ra;
        v.e_data = ed; v.e_busy = eb; v.e_cnt = ec; v.e_idle = ei;
        return v;
    endfunction

    // Reference model: k=0 is instance A (bypass), k=1 is instance B (zero register).
    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 8; a++) begin
                m_reg[k][a]  = '0;
                m_busy[k][a] = 1'b0;
            end
        end
    endtask

    task automatic model_read(input int k, input logic [2:0] a,
                              output logic [15:0] d, output logic b);
        bit zr, bp, w, c;
        zr = (k == 1);
        bp = (k == 0);
        w  = wr_en && !(zr && wr_addr == 3'd0);
        c  = claim && !(zr && claim_addr == 3'd0);
        d  = m_reg[k][a];
        b  = m_busy[k][a];
        if (bp && w && wr_addr == a) begin
            d = wr_data;
            b = (c && claim_addr == a) ? m_busy[k][a] : 1'b0;
        end
        if (zr && a == 3'd0) begin
            d = '0;
            b = 1'b0;
        end
    endtask

    task automatic model_step();
        bit zr, w, c;
        for (int k = 0; k < 2; k++) begin
            zr = (k == 1);
            w  = wr_en && !(zr && wr_addr == 3'd0);
            c  = claim && !(zr && claim_addr == 3'd0);
            if (w) m_reg[k][wr_addr] = wr_data;
            if (flush) begin
                for (int a = 0; a < 8; a++) m_busy[k][a] = 1'b0;
            end else if (w) begin
                m_busy[k][wr_addr] = 1'b0;
            end
            if (c) m_busy[k][claim_addr] = 1'b1;
        end
    endtask

    function automatic int model_count(input int k);
        int n = 0;
        for (int a = 0; a < 8; a++) n += int'(m_busy[k][a]);
        return n;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_data_a"}, rd_data_a, 32'h0);
        check({tag, "_data_b"}, rd_data_b, 32'h0);
        check({tag, "_busy_a"}, {30'd0, rd_busy_a}, 32'h0);
        check({tag, "_busy_b"}, {30'd0, rd_busy_b}, 32'h0);
        check({tag, "_cnt_a"}, {28'd0, cnt_a}, 32'h0);
        check({tag, "_cnt_b"}, {28'd0, cnt_b}, 32'h0);
        check({tag, "_idle_a"}, {31'd0, idle_a}, 32'h1);
        check({tag, "_idle_b"}, {31'd0, idle_b}, 32'h1);
    endtask

    initial begin
        logic [15:0] ed;
        logic        eb;
        logic [2:0]  ra;

        //            cl  ca   we  wa   wd        fl  ra   e_data    eb  cnt  idle
        tbl[0]  = mk(0, 3'd0, 1, 3'd3, 16'hA5A5, 0, 3'd3, 16'hA5A5, 0, 4'd0, 1);
        tbl[1]  = mk(0, 3'd0, 0, 3'd0, 16'h0000, 0, 3'd3, 16'hA5A5, 0, 4'd0, 1);
        tbl[2]  = mk(1, 3'd2, 0, 3'd0, 16'h0000, 0, 3'd2, 16'h0000, 0, 4'd1, 0);
        tbl[3]  = mk(1, 3'd5, 0, 3'd0, 16'h0000, 0, 3'd2, 16'h0000, 1, 4'd2, 0);
        tbl[4]  = mk(0, 3'd0, 0, 3'd0, 16'h0000, 0, 3'd5, 16'h0000, 1, 4'd2, 0);
        tbl[5]  = mk(0, 3'd0, 1, 3'd2, 16'h1234, 0, 3'd2, 16'h1234, 0, 4'd1, 0);
        tbl[6]  = mk(0, 3'd0, 0, 3'd0, 16'h0000, 0, 3'd2, 16'h1234, 0, 4'd1, 0);
        tbl[7]  = mk(1, 3'd4, 1, 3'd4, 16'h0042, 0, 3'd4, 16'h0042, 0, 4'd2, 0);
        tbl[8]  = mk(1, 3'd1, 0, 3'd0, 16'h0000, 0, 3'd4, 16'h0042, 1, 4'd3, 0);
        tbl[9]  = mk(1, 3'd6, 0, 3'd0, 16'h0000, 1, 3'd6, 16'h0000, 0, 4'd1, 0);
        tbl[10] = mk(0, 3'd0, 0, 3'd0, 16'h0000, 0, 3'd6, 16'h0000, 1, 4'd1, 0);
        tbl[11] = mk(0, 3'd0, 0, 3'd0, 16'h0000, 0, 3'd5, 16'h0000, 0, 4'd1, 0);
        tbl[12] = mk(0, 3'd0, 1, 3'd6, 16'h0007, 0, 3'd6, 16'h0007, 0, 4'd0, 1);
        tbl[13] = mk(1, 3'd6, 0, 3'd0, 16'h0000, 0, 3'd6, 16'h0007, 0, 4'd1, 0);
        tbl[14] = mk(1, 3'd6, 0, 3'd0, 16'h0000, 0, 3'd6, 16'h0007, 1, 4'd1, 0);
        tbl[15] = mk(1, 3'd6, 1, 3'd6, 16'h0009, 0, 3'd6, 16'h0009, 1, 4'd1, 0);
        tbl[16] = mk(0, 3'd0, 0, 3'd0, 16'h0000, 0, 3'd6, 16'h0009, 1, 4'd1, 0);

        reset = 1'b0;
        drive(0, 3'd0, 0, 3'd0, 16'h0, 0, {3'd3, 3'd5});
        #1 check_reset_values("reset");
        @(posedge clock); #2;
        check_reset_values("reset_hold");
        @(negedge clock);
        reset = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clock);
            drive(tbl[i].cl, tbl[i].ca, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].fl,
                  {tbl[i].ra, 3'd0});
            #2;
            check($sformatf("vec%0d_data", i), {16'd0, rd_data_a[31:16]}, {16'd0, tbl[i].e_data});
            check($sformatf("vec%0d_busy", i), {31'd0, rd_busy_a[1]}, {31'd0, tbl[i].e_busy});
            @(posedge clock); #1;
            check($sformatf("vec%0d_cnt", i), {28'd0, cnt_a}, {28'd0, tbl[i].e_cnt});
            check($sformatf("vec%0d_idle", i), {31'd0, idle_a}, {31'd0, tbl[i].e_idle});
        end

        // Zero register: write and claim r0 on both instances; only A takes them.
        @(negedge clock);
        drive(1, 3'd0, 1, 3'd0, 16'hFFFF, 0, {3'd0, 3'd0});
        #2;
        check("zr_same_data_b", {16'd0, rd_data_b[31:16]}, 32'h0);
        check("zr_same_busy_b", {31'd0, rd_busy_b[1]}, 32'h0);
        check("zr_same_data_a", {16'd0, rd_data_a[31:16]}, 32'hFFFF);
        @(posedge clock); #1;
        check("zr_cnt_b", {28'd0, cnt_b}, 32'd1);
        check("zr_cnt_a", {28'd0, cnt_a}, 32'd2);
        @(negedge clock);
        drive(0, 3'd0, 0, 3'd0, 16'h0, 0, {3'd0, 3'd0});
        #2;
        check("zr_next_data_b", {16'd0, rd_data_b[31:16]}, 32'h0);
        check("zr_next_busy_b", {31'd0, rd_busy_b[1]}, 32'h0);
        check("zr_next_data_a", {16'd0, rd_data_a[31:16]}, 32'hFFFF);
        check("zr_next_busy_a", {31'd0, rd_busy_a[1]}, 32'h1);
        check("zr_idle_b", {31'd0, idle_b}, 32'h0);

        // Without bypass the same-cycle read returns the old value, the new one a cycle later.
        @(negedge clock);
        drive(0, 3'd0, 1, 3'd3, 16'hBEEF, 0, {3'd3, 3'd3});
        #2;
        check("nobp_same_b", {16'd0, rd_data_b[31:16]}, 32'hA5A5);
        check("bp_same_a", {16'd0, rd_data_a[31:16]}, 32'hBEEF);
        @(posedge clock); #1;
        check("nobp_next_b", {16'd0, rd_data_b[31:16]}, 32'hBEEF);

        // Randomized run against the model, with a reset pulse in the middle.
        @(negedge clock);
        drive(0, 3'd0, 0, 3'd0, 16'h0, 0, 6'd0);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        model_reset();

        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clock);
            if (cyc == 5000) begin
                drive(0, 3'd0, 0, 3'd0, 16'h0, 0, 6'($urandom));
                #1 reset = 1'b0;
                #1 check_reset_values("mid_reset");
                #1 reset = 1'b1;
                model_reset();
            end else begin
                drive(($urandom_range(0, 2) == 0), 3'($urandom), $urandom_range(0, 1) == 1,
                      3'($urandom), 16'($urandom), ($urandom_range(0, 19) == 0), 6'($urandom));
                #2;
                for (int p = 0; p < 2; p++) begin
                    ra = rd_addr[p*3 +: 3];
                    model_read(0, ra, ed, eb);
                    check("rand_data_a", {16'd0, rd_data_a[p*16 +: 16]}, {16'd0, ed});
                    check("rand_busy_a", {31'd0, rd_busy_a[p]}, {31'd0, eb});
                    model_read(1, ra, ed, eb);
                    check("rand_data_b", {16'd0, rd_data_b[p*16 +: 16]}, {16'd0, ed});
                    check("rand_busy_b", {31'd0, rd_busy_b[p]}, {31'd0, eb});
                end
                @(posedge clock);
                model_step();
                #1;
                check("rand_cnt_a", {28'd0, cnt_a}, 32'(model_count(0)));
                check("rand_cnt_b", {28'd0, cnt_b}, 32'(model_count(1)));
                check("rand_idle_a", {31'd0, idle_a}, {31'd0, model_count(0) == 0});
                check("rand_idle_b", {31'd0, idle_b}, {31'd0, model_count(1) == 0});
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised general-purpose register file with an integrated busy-bit scoreboard, for the pipelined datapath. It supports configurable width, depth and number of read ports, an optional write-to-read bypass and an optional hard-wired zero register. Each register carries a busy bit that the issue stage sets when it claims a register as a destination. Writeback clears the bit; the hazard logic reads it to stall.

## Interface
- `WIDTH`, 16: data bits per register
- `DEPTH`, 8: number of registers (power of two, ≥2); `AW = $clog2(DEPTH)`
- `NREAD`, 2: number of read ports (≥1)
- `BYPASS`, 1: 1 = same-cycle write data forwarded to read ports
- `ZERO_R0`, 0: 1 = register 0 reads 0, ignores writes and claims
- `CW`, derived: `$clog2(DEPTH+1)`

Ports:
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low; clears all state
- `rd_addr`  in  NREAD*AW  read addresses, port i at `[i*AW +: AW]`
- `rd_data`  out  NREAD*WIDTH  read data, port i at `[i*WIDTH +: WIDTH]`
- `rd_busy`  out  NREAD  busy bit of each addressed register
- `wr_en`  in  1  writeback strobe
- `wr_addr`  in  AW  writeback register
- `wr_data`  in  WIDTH  writeback data
- `claim`  in  1  issue stage claims a destination register
- `claim_addr`  in  AW  register claimed
- `flush`  in  1  synchronous clear of all busy bits (pipeline flush)
- `busy_count`  out  CW  number of busy registers
- `all_idle`  out  1  `busy_count == 0`

## Operation
- Effective write `we_e = wr_en & ~(ZERO_R0 & wr_addr==0)`; effective claim `cl_e = claim & ~(ZERO_R0 & claim_addr==0)`.
- Data: on `we_e`, `r[wr_addr] <= wr_data`. Writes are accepted whether or not the target is busy. `flush` does not block writes.
- Busy next-state per register a, priority high→low:
  - `cl_e & claim_addr==a` → 1
  - `flush` → 0
  - `we_e & wr_addr==a` → 0
  - else hold
- Claim and write to the same register in the same cycle: claim wins, busy stays 1, and the data is still written. This is the new-producer case.
- Claim of an already-busy register (WAW) is legal; busy stays 1.
- `busy_count` is maintained incrementally and must always equal the popcount of the busy bits. With `flush`, the next value is `cl_e ? 1 : 0`.
- Reads are combinational per port. Data is `r[rd_addr]`; with `ZERO_R0` and addr 0, data = 0 and busy = 0.
- With `BYPASS=1` and `we_e & wr_addr==rd_addr`: `rd_data = wr_data`. `rd_busy` = 0 unless the same register is claimed this cycle, in which case it is the registered busy value.
- With `BYPASS=0`: reads return the registered value.
- Out-of-range behaviour cannot occur because DEPTH is a power of two.

## Timing
- Reset asserted (`reset`=0): all registers 0, busy bits 0, `busy_count` 0, `all_idle` 1. These values hold until the first rising edge after release.
- Write latency:
  - 1 cycle to registered read.
  - 0 cycles via bypass (`BYPASS=1`).
- Claim/flush latency: busy bits, `busy_count` and `all_idle` update on the edge; visible next cycle.
- Reset mid-operation overrides any in-flight write, claim or flush. No partial update is allowed.
- `all_idle` is derived from the registered `busy_count` and is glitch-free relative to the clock.

## Structure
- Shared package `regfile_pkg`: default `WIDTH`/`DEPTH`/`NREAD` constants and the `AW`/`CW` derivation functions, reused by decode and hazard units.
- Sub-module `busy_scoreboard`:
  - Contains the busy bit vector, the priority next-state logic and the incremental counter.
  - Ports: `clock`, `reset`, `claim`, `claim_addr`, `wr_en`, `wr_addr`, `flush`, `busy`, `busy_count`.
- The top level holds the storage array, the read mux/bypass generate loop and the zero-register masking.

## Test plan
- Reset, then write 16'hA5A5 to r3 and read r3 on port 1 the next cycle: data A5A5. With `BYPASS=1`, the same-cycle read also returns A5A5.
- Claim r2 then r5: `busy_count` 1 then 2, `rd_busy` high for both. Write r2: count 1, r2 busy 0.
- Same cycle: claim r4 and write r4 = 16'h0042. r4 busy stays 1, count +1, and the next-cycle read returns 0042.
- With 3 registers busy, assert `flush` together with claim r6: next cycle `busy_count` = 1, only r6 busy, `all_idle` 0.
- `ZERO_R0=1`: write 16'hFFFF to r0 and claim r0. r0 reads 0, busy 0, count unchanged.
- Random claim/write/flush for 10k cycles with an assertion `busy_count == popcount(busy)`. Pulse reset mid-burst: all outputs return to reset values immediately.
